parity_frame_unit: RTL
======================

# parity_frame_unit

Streaming, parametrised parity generator/checker that supersedes the fixed 4-input even-parity gate. It accepts a frame of `FRAME_LEN` words of `WIDTH` bits over a valid/ready handshake and accumulates the XOR of every bit in the frame. When the frame completes, it emits one parity bit in even or odd mode, together with a mismatch flag against a received parity bit. It sits between a word source (switch/UART front end) and the frame consumer or error LED logic.

## Interface
Parameters:
- `WIDTH`, 8: bits per input word, ≥1.
- `FRAME_LEN`, 4: words per frame, ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  `WIDTH`  word payload.
- `in_par`  in  1  received parity bit; sampled only with the last word of a frame.
- `mode_odd`  in  1  0 = even parity, 1 = odd parity; sampled only with the last word.
- `flush`  in  1  synchronous abort of the current frame.
- `out_valid`  out  1  frame result is available.
- `out_ready`  in  1  consumer takes the result.
- `out_parity`  out  1  generated parity bit.
- `out_err`  out  1  `out_parity != in_par` for the frame.
- `word_cnt`  out  `$clog2(FRAME_LEN+1)`  number of words accepted in the current frame.

## Operation
- FSM has two states:
  - ACC (reset state): `in_ready = 1`, `out_valid = 0`.
  - OUT: `in_ready = 0`, `out_valid = 1`.
- **ACC, word accepted** (`in_valid & in_ready`): `acc <= acc ^ (^in_data)`, `word_cnt <= word_cnt + 1`.
- **Last word** (`word_cnt == FRAME_LEN-1` and a word is accepted):
  - `out_parity <= acc ^ (^in_data) ^ mode_odd`
  - `out_err <= that value ^ in_par`
  - `acc <= 0`, `word_cnt <= 0`, go to OUT.
- **OUT**: `out_parity`/`out_err` are held stable until `out_ready` is 1, then return to ACC. There is no accept in OUT.
- **Even mode** result is the XOR of all frame bits. For `WIDTH = 4`, `FRAME_LEN = 1` this equals the legacy gate.
- **Flush**:
  - In ACC: clears `acc` and `word_cnt`; a word offered in the same cycle is dropped (flush wins).
  - In OUT: discards the result, clears `out_valid`, and returns to ACC.
- **Reset**:
  - While `rst = 1`, `in_ready = 0` and no word is accepted.
  - After the first edge with `rst = 1`: state ACC, `acc = 0`, `word_cnt = 0`, `out_valid = 0`, `out_parity = 0`, `out_err = 0`.
  - Reset mid-frame or mid-OUT loses the partial frame or the pending result.
- **`FRAME_LEN = 1`**: every accepted word completes a frame.

## Timing
- Latency: last word accepted on edge k → `out_valid = 1` in the cycle after edge k.
- `out_valid` stays high until the edge where `out_ready = 1`; `in_ready` returns high in the following cycle.
- Back-to-back frames cost exactly one bubble cycle when `out_ready` is tied high.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`.
- `word_cnt` never exceeds `FRAME_LEN-1` in ACC and reads 0 in OUT.

## Structure
- Package `parity_pkg`:
  - State encoding constants `ST_ACC = 1'b0`, `ST_OUT = 1'b1`.
  - Count-width helper function.
- Sub-module `word_parity #(WIDTH)`: combinational reduction XOR of one word. It is instantiated once on `in_data` and is reusable by the per-word checker planned next.
- The top holds the FSM, the counter, the accumulator and the output registers.

## Test plan
All scenarios use `WIDTH = 8`, `FRAME_LEN = 4` unless stated.
- **Even frame**: words 0x01, 0x03, 0x07, 0x0F, `mode_odd = 0`, `in_par = 0` → `out_parity = 0`, `out_err = 0`, `out_valid` high one cycle after the 4th accept.
- **Odd mode and mismatch**: same words, `mode_odd = 1`, `in_par = 0` → `out_parity = 1`, `out_err = 1`. Words 0xFF, 0x00, 0x00, 0x80 in even mode → `out_parity = 1`.
- **Backpressure**: `out_ready = 0` for 5 cycles → `out_valid`/`out_parity` held; `in_ready = 0` throughout; frame 2 accepted only after `out_ready` pulses.
- **Flush**: 2 words, then `flush` asserted together with `in_valid` → `word_cnt = 0`; the next 4 words produce a result based only on those 4 words.
- **Reset mid-frame**: 3 words, then `rst` for 1 cycle → all outputs 0, `word_cnt = 0`; a fresh frame of 4 words completes normally.
- **Legacy equivalence**: `WIDTH = 4`, `FRAME_LEN = 1`, all 16 nibbles, even mode → `out_parity` matches the XOR of the 4 bits for every nibble.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame unit: FSM state encoding and
// the helper that sizes the word counter.
package parity_pkg;

  localparam logic ST_ACC = 1'b0;
  localparam logic ST_OUT = 1'b1;

  // Width of a counter able to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_parity.sv
// Combinational reduction XOR of one input word. A small separate block so
// that a per-word checker can reuse it.
module word_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_par
);

  assign o_par = ^i_data;

endmodule

// File: rtl/parity_frame_unit.sv
// Streaming parity generator/checker. It XORs every bit of a FRAME_LEN-word
// frame and then presents one parity bit (even or odd) plus a mismatch flag
// against the received parity bit. It uses a two-state FSM: accumulate, then
// hold the result until the consumer takes it.
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_par,
  input  logic                                mode_odd,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_parity,
  output logic                                out_err,
  output logic [cnt_width(FRAME_LEN)-1:0]     word_cnt
);

  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic             r_state;
  logic             w_state_nxt;
  logic             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_err;

  logic             w_word_par;
  logic             w_accept;
  logic             w_last;
  logic             w_frame_par;

  word_parity #(.WIDTH(WIDTH)) u_word_parity (
    .i_data (in_data),
    .o_par  (w_word_par)
  );

  // A flush in the same cycle beats an offered word, so the word is dropped.
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_last      = w_accept && (r_cnt == LAST_IDX);
  assign w_frame_par = r_acc ^ w_word_par ^ mode_odd;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: the last word closes the frame; a take or a flush releases the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (out_ready || flush) w_state_nxt = ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Handshake outputs decoded from registered state only; in_ready is also held low during reset.
  always_comb begin
    in_ready  = (r_state == ST_ACC) && !rst;
    out_valid = (r_state == ST_OUT);
  end

  // Accumulator, word counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 1'b0;
      r_cnt <= '0;
      r_par <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == ST_ACC) begin
      if (flush) begin
        r_acc <= 1'b0;
        r_cnt <= '0;
      end else if (w_last) begin
        r_acc <= 1'b0;
        r_cnt <= '0;
        r_par <= w_frame_par;
        r_err <= w_frame_par ^ in_par;
      end else if (w_accept) begin
        r_acc <= r_acc ^ w_word_par;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_parity = r_par;
  assign out_err    = r_err;
  assign word_cnt   = r_cnt;

endmodule
